// File: rtl/uzorak_loader_if.sv
// Feature-stream and packed-frame port bundle for uzorak_loader.
// slave = loader side, master = producer/consumer side.
interface uzorak_loader_if #(
  parameter int unsigned N_FEAT = 60,
  parameter int unsigned W      = 16
);
  logic [W-1:0]        feat_in;
  logic                feat_valid;
  logic                feat_ready;
  logic [N_FEAT*W-1:0] uzorak;
  logic                uzorak_valid;
  logic                uzorak_ack;
  logic [5:0]          feat_idx;
  logic                frame_err;

  modport master (
    output feat_in, feat_valid, uzorak_ack,
    input  feat_ready, uzorak, uzorak_valid, feat_idx, frame_err
  );

  modport slave (
    input  feat_in, feat_valid, uzorak_ack,
    output feat_ready, uzorak, uzorak_valid, feat_idx, frame_err
  );
endinterface

// File: rtl/uzorak_loader.sv
// Serial-to-parallel loader: packs N_FEAT W-bit features into one frame and holds it until acked.
// Optional partial-frame timeout is enabled by defining UZORAK_LOADER_TIMEOUT_EN.
module uzorak_loader #(
  parameter int unsigned N_FEAT  = 60,
  parameter int unsigned W       = 16,
  parameter int unsigned TIMEOUT = 1024
) (
  input logic            clk,
  input logic            rst,
  uzorak_loader_if.slave bus
);

  localparam int unsigned FW = N_FEAT * W;
  localparam int unsigned IW = 6;

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] FULL = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [FW-1:0] uzorak_q, uzorak_d;
  logic          uzorak_valid_q, uzorak_valid_d;
  logic [IW-1:0] feat_idx_q, feat_idx_d;
  logic          xfer;

`ifdef UZORAK_LOADER_TIMEOUT_EN
  localparam int unsigned GW = $clog2(TIMEOUT + 1);
  logic [GW-1:0] gap_q, gap_d;
  logic          frame_err_q, frame_err_d;
`endif

  // Ready depends only on state so the producer never sees a combinational loop.
  assign bus.feat_ready = (state_q == FILL) && !rst;
  assign xfer           = bus.feat_valid && bus.feat_ready;

  always_comb begin
    state_d        = state_q;
    uzorak_d       = uzorak_q;
    uzorak_valid_d = uzorak_valid_q;
    feat_idx_d     = feat_idx_q;
`ifdef UZORAK_LOADER_TIMEOUT_EN
    gap_d          = '0;
    frame_err_d    = 1'b0;
`endif
    case (state_q)
      FILL: begin
        if (xfer) begin
          uzorak_d = {uzorak_q[FW-W-1:0], bus.feat_in};
          if (feat_idx_q == IW'(N_FEAT - 1)) begin
            feat_idx_d     = '0;
            uzorak_valid_d = 1'b1;
            state_d        = FULL;
          end else begin
            feat_idx_d = feat_idx_q + IW'(1);
          end
        end
`ifdef UZORAK_LOADER_TIMEOUT_EN
        // Idle gap inside a partial frame: count, and drop the frame once it hits TIMEOUT.
        else if (feat_idx_q != '0) begin
          if (gap_q == GW'(TIMEOUT - 1)) begin
            feat_idx_d  = '0;
            uzorak_d    = '0;
            frame_err_d = 1'b1;
          end else begin
            gap_d = gap_q + GW'(1);
          end
        end
`endif
      end
      FULL: begin
        if (bus.uzorak_ack) begin
          uzorak_valid_d = 1'b0;
          state_d        = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= FILL;
      uzorak_q       <= '0;
      uzorak_valid_q <= 1'b0;
      feat_idx_q     <= '0;
`ifdef UZORAK_LOADER_TIMEOUT_EN
      gap_q          <= '0;
      frame_err_q    <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      uzorak_q       <= uzorak_d;
      uzorak_valid_q <= uzorak_valid_d;
      feat_idx_q     <= feat_idx_d;
`ifdef UZORAK_LOADER_TIMEOUT_EN
      gap_q          <= gap_d;
      frame_err_q    <= frame_err_d;
`endif
    end
  end

  assign bus.uzorak       = uzorak_q;
  assign bus.uzorak_valid = uzorak_valid_q;
  assign bus.feat_idx     = feat_idx_q;
`ifdef UZORAK_LOADER_TIMEOUT_EN
  assign bus.frame_err    = frame_err_q;
`else
  assign bus.frame_err    = 1'b0;
`endif

endmodule

// File: tb/tb_uzorak_loader.sv
// Testbench for uzorak_loader: random streams checked against a queue-based frame model.
module tb_uzorak_loader;

  localparam int unsigned NF = 60;
  localparam int unsigned FW = NF * 16;
  localparam int unsigned TO = 8;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  uzorak_loader_if #(.N_FEAT(NF), .W(16)) bus ();

  uzorak_loader #(.N_FEAT(NF), .W(16), .TIMEOUT(TO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: words accepted so far in the current frame, and the last completed frame.
  logic [15:0]   m_q[$];
  logic          m_full;
  logic [FW-1:0] m_frame;
  logic          m_err;
  int            m_gap;

  function automatic logic [FW-1:0] pack_frame(input logic [15:0] w[$]);
    logic [FW-1:0] f;
    f = '0;
    for (int k = 0; k < w.size(); k++) f[(NF-1-k)*16 +: 16] = w[k];
    return f;
  endfunction

  // Advance the model by one clock edge using the currently driven inputs, then step the clock.
  task automatic cycle();
    m_err = 1'b0;
    if (rst) begin
      m_q.delete();
      m_full  = 1'b0;
      m_frame = '0;
      m_gap   = 0;
    end else if (!m_full) begin
      if (bus.feat_valid) begin
        m_q.push_back(bus.feat_in);
        m_gap = 0;
        if (m_q.size() == NF) begin
          m_frame = pack_frame(m_q);
          m_full  = 1'b1;
          m_q.delete();
        end
      end else if (m_q.size() > 0) begin
`ifdef UZORAK_LOADER_TIMEOUT_EN
        m_gap++;
        if (m_gap == TO) begin
          m_q.delete();
          m_gap = 0;
          m_err = 1'b1;
        end
`endif
      end
    end else begin
      m_gap = 0;
      if (bus.uzorak_ack) m_full = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    checks++; if (bus.uzorak_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", bus.uzorak_valid); end
    checks++; if (bus.feat_idx !== 6'd0) begin errors++; $display("FAIL rst_idx: got %0d expected 0", bus.feat_idx); end
    checks++; if (bus.uzorak !== '0) begin errors++; $display("FAIL rst_uzorak: got nonzero expected 0"); end
    checks++; if (bus.feat_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b expected 0", bus.feat_ready); end
    checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", bus.frame_err); end
    rst = 1'b0;
    #1;
    checks++; if (bus.feat_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after: got %b expected 1", bus.feat_ready); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < NF; i++) begin
      bus.feat_valid = 1'b1;
      bus.feat_in    = 16'(i);
      cycle();
      checks++; if (bus.uzorak_valid !== m_full) begin errors++; $display("FAIL b2b_valid[%0d]: got %b expected %b", i, bus.uzorak_valid, m_full); end
      checks++; if (bus.feat_idx !== 6'(m_q.size())) begin errors++; $display("FAIL b2b_idx[%0d]: got %0d expected %0d", i, bus.feat_idx, m_q.size()); end
    end
    bus.feat_valid = 1'b0;
    checks++; if (bus.uzorak_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid_rise: got %b expected 1", bus.uzorak_valid); end
    checks++; if (bus.uzorak[959:944] !== 16'h0000) begin errors++; $display("FAIL b2b_first: got %h expected 0000", bus.uzorak[959:944]); end
    checks++; if (bus.uzorak[15:0] !== 16'h003B) begin errors++; $display("FAIL b2b_last: got %h expected 003b", bus.uzorak[15:0]); end
    checks++; if (bus.uzorak !== m_frame) begin errors++; $display("FAIL b2b_frame: got f0=%h f59=%h expected f0=%h f59=%h", bus.uzorak[959:944], bus.uzorak[15:0], m_frame[959:944], m_frame[15:0]); end
    checks++; if (bus.feat_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready: got %b expected 0", bus.feat_ready); end
  endtask

  task automatic test_full_hold();
    bus.feat_valid = 1'b1;
    bus.feat_in    = 16'hFFFF;
    for (int i = 0; i < 20; i++) begin
      cycle();
      checks++; if (bus.uzorak !== m_frame) begin errors++; $display("FAIL hold_uzorak[%0d]: got f59=%h expected f59=%h", i, bus.uzorak[15:0], m_frame[15:0]); end
      checks++; if (bus.feat_idx !== 6'd0 || bus.feat_ready !== 1'b0 || bus.uzorak_valid !== 1'b1) begin
        errors++; $display("FAIL hold_ctrl[%0d]: got idx=%0d rdy=%b vld=%b expected 0 0 1", i, bus.feat_idx, bus.feat_ready, bus.uzorak_valid);
      end
    end
    bus.feat_valid = 1'b0;
    bus.uzorak_ack = 1'b1;
    cycle();
    bus.uzorak_ack = 1'b0;
    checks++; if (bus.uzorak_valid !== 1'b0) begin errors++; $display("FAIL ack_valid: got %b expected 0", bus.uzorak_valid); end
    checks++; if (bus.feat_idx !== 6'd0) begin errors++; $display("FAIL ack_idx: got %0d expected 0", bus.feat_idx); end
    checks++; if (bus.feat_ready !== 1'b1) begin errors++; $display("FAIL ack_ready: got %b expected 1", bus.feat_ready); end
    checks++; if (bus.uzorak !== m_frame) begin errors++; $display("FAIL ack_keep: got f59=%h expected f59=%h", bus.uzorak[15:0], m_frame[15:0]); end
  endtask

  task automatic test_gaps();
    logic [15:0]   ref_w[$];
    logic [FW-1:0] ref_f;
    int            sent = 0;
    int            budget = 2000;
    for (int i = 0; i < NF; i++) ref_w.push_back(16'h1000 + 16'(i));
    ref_f = pack_frame(ref_w);
    bus.uzorak_ack = 1'b1;  // ignored while filling
    while (!m_full && budget > 0) begin
      bus.feat_valid = 1'($urandom_range(0, 1));
      bus.feat_in    = bus.feat_valid ? 16'h1000 + 16'(sent) : 16'($urandom);
      if (bus.feat_valid) sent++;
      if (sent == NF) bus.uzorak_ack = 1'b0;
      cycle();
      budget--;
      checks++; if (bus.feat_idx !== 6'(m_q.size())) begin errors++; $display("FAIL gap_idx: got %0d expected %0d", bus.feat_idx, m_q.size()); end
    end
    bus.feat_valid = 1'b0;
    bus.uzorak_ack = 1'b0;
    checks++; if (!m_full) begin errors++; $display("FAIL gap_timeout: got no frame expected frame within budget"); end
    checks++; if (bus.uzorak_valid !== 1'b1) begin errors++; $display("FAIL gap_valid: got %b expected 1", bus.uzorak_valid); end
    checks++; if (bus.uzorak !== ref_f) begin errors++; $display("FAIL gap_frame: got f0=%h f59=%h expected f0=%h f59=%h", bus.uzorak[959:944], bus.uzorak[15:0], ref_f[959:944], ref_f[15:0]); end
    bus.uzorak_ack = 1'b1;
    cycle();
    bus.uzorak_ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 30; i++) begin
      bus.feat_valid = 1'b1;
      bus.feat_in    = 16'h5000 + 16'(i);
      cycle();
    end
    bus.feat_valid = 1'b1;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cycle();
      checks++; if (bus.uzorak_valid !== 1'b0 || bus.feat_idx !== 6'd0 || bus.uzorak !== '0) begin
        errors++; $display("FAIL midrst_state: got vld=%b idx=%0d expected 0 0 with cleared frame", bus.uzorak_valid, bus.feat_idx);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < NF; i++) begin
      bus.feat_in = 16'hA000 + 16'(i);
      cycle();
    end
    bus.feat_valid = 1'b0;
    checks++; if (bus.uzorak_valid !== 1'b1) begin errors++; $display("FAIL midrst_valid: got %b expected 1", bus.uzorak_valid); end
    checks++; if (bus.uzorak[959:944] !== 16'hA000) begin errors++; $display("FAIL midrst_first: got %h expected a000", bus.uzorak[959:944]); end
    checks++; if (bus.uzorak !== m_frame) begin errors++; $display("FAIL midrst_frame: got f0=%h f59=%h expected f0=%h f59=%h", bus.uzorak[959:944], bus.uzorak[15:0], m_frame[959:944], m_frame[15:0]); end
    bus.uzorak_ack = 1'b1;
    cycle();
    bus.uzorak_ack = 1'b0;
  endtask

  task automatic test_ack_tied();
    int   rises[$];
    logic prev = 1'b0;
    bus.uzorak_ack = 1'b1;
    bus.feat_valid = 1'b1;
    for (int c = 0; c < 131; c++) begin
      bus.feat_in = 16'($urandom);
      cycle();
      checks++; if (bus.uzorak_valid !== m_full) begin errors++; $display("FAIL tied_valid[%0d]: got %b expected %b", c, bus.uzorak_valid, m_full); end
      if (bus.uzorak_valid === 1'b1) begin
        rises.push_back(c);
        checks++; if (bus.uzorak !== m_frame) begin errors++; $display("FAIL tied_frame[%0d]: got f59=%h expected f59=%h", c, bus.uzorak[15:0], m_frame[15:0]); end
        checks++; if (prev === 1'b1) begin errors++; $display("FAIL tied_width[%0d]: got 2+ cycle pulse expected 1", c); end
      end
      prev = bus.uzorak_valid;
    end
    bus.feat_valid = 1'b0;
    bus.uzorak_ack = 1'b0;
    checks++; if (rises.size() != 2) begin errors++; $display("FAIL tied_count: got %0d expected 2", rises.size()); end
    else begin
      checks++; if (rises[0] != NF - 1) begin errors++; $display("FAIL tied_first: got %0d expected %0d", rises[0], NF - 1); end
      checks++; if (rises[1] - rises[0] != NF + 1) begin errors++; $display("FAIL tied_period: got %0d expected %0d", rises[1] - rises[0], NF + 1); end
    end
  endtask

  task automatic test_timeout();
    int err_pulses = 0;
    int idle_n;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.feat_valid = 1'b1;
      bus.feat_in    = 16'h7700 + 16'(i);
      cycle();
    end
    bus.feat_valid = 1'b0;
`ifdef UZORAK_LOADER_TIMEOUT_EN
    idle_n = TO + 4;
`else
    idle_n = 48;
`endif
    for (int i = 0; i < idle_n; i++) begin
      cycle();
      if (bus.frame_err === 1'b1) err_pulses++;
      checks++; if (bus.frame_err !== m_err) begin errors++; $display("FAIL to_err[%0d]: got %b expected %b", i, bus.frame_err, m_err); end
      checks++; if (bus.feat_idx !== 6'(m_q.size())) begin errors++; $display("FAIL to_idx[%0d]: got %0d expected %0d", i, bus.feat_idx, m_q.size()); end
    end
`ifdef UZORAK_LOADER_TIMEOUT_EN
    checks++; if (err_pulses != 1) begin errors++; $display("FAIL to_pulses: got %0d expected 1", err_pulses); end
`else
    checks++; if (err_pulses != 0) begin errors++; $display("FAIL to_pulses: got %0d expected 0", err_pulses); end
`endif
    bus.feat_valid = 1'b1;
    for (int i = 0; i < NF && !m_full; i++) begin
      bus.feat_in = 16'h3300 + 16'(i);
      cycle();
    end
    bus.feat_valid = 1'b0;
    checks++; if (bus.uzorak_valid !== 1'b1) begin errors++; $display("FAIL to_valid: got %b expected 1", bus.uzorak_valid); end
    checks++; if (bus.uzorak !== m_frame) begin errors++; $display("FAIL to_frame: got f0=%h f59=%h expected f0=%h f59=%h", bus.uzorak[959:944], bus.uzorak[15:0], m_frame[959:944], m_frame[15:0]); end
    bus.uzorak_ack = 1'b1;
    cycle();
    bus.uzorak_ack = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    bus.feat_in    = '0;
    bus.feat_valid = 1'b0;
    bus.uzorak_ack = 1'b0;
    m_full         = 1'b0;
    m_frame        = '0;
    m_err          = 1'b0;
    m_gap          = 0;
    test_reset();
    test_back_to_back();
    test_full_hold();
    test_gaps();
    test_reset_mid();
    test_ack_tied();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
